abr_ckt: RTL and testbench

- UART auto-baud rate detector in the style of a PIC `ABAUD` circuit; sits beside the UART receiver on the RX pin.
- While armed by `ABAUD`, it measures a received 0x55 sync character (LSB first, idle-high line) and outputs the bit period in prescaled clock ticks.
- Completion raises interrupt flag `UxRXIF`. An internal oscillator/prescaler generates the counting tick.

---
 rtl/abr_ckt.sv | 160 ++++++++++++++++
 tb/tb_abr_ckt.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/abr_ckt.sv
// UART auto-baud detector: times a received 0x55 sync character and reports the bit period.
// Optional macro ABR_OVF_EN adds the ABDOVF counter-overflow output.
module abr_ckt #(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ABAUD,
  input  logic       UxRX,
  output logic       UxRXIF,
`ifdef ABR_OVF_EN
  output logic       ABDOVF,
`endif
  output logic [7:0] out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    WAIT_R1    = 3'd2,
    MEASURE    = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [1:0]         sync_reg;
  logic               rx_prev_reg;
  logic               rise;
  logic               fall;
  logic               tick;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2:0]         edge_cnt_reg;
  logic               cnt_max;
  logic               start_meas;

  // Two-flop synchronizer followed by a previous-value register for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], UxRX};
      rx_prev_reg <= sync_reg[1];
    end
  end

  assign rise = sync_reg[1] & ~rx_prev_reg;
  assign fall = ~sync_reg[1] & rx_prev_reg;

  generate
    if (PRESCALE > 1) begin : g_prescale
      localparam int PS_W = $clog2(PRESCALE);
      logic [PS_W-1:0] ps_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ps_reg <= '0;
        end else if (ps_reg == PS_W'(PRESCALE - 1)) begin
          ps_reg <= '0;
        end else begin
          ps_reg <= ps_reg + 1'b1;
        end
      end

      assign tick = (ps_reg == PS_W'(PRESCALE - 1));
    end else begin : g_no_prescale
      assign tick = 1'b1;
    end
  endgenerate

  assign cnt_max = &cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_meas = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ABAUD && !UxRXIF) state_next = WAIT_START;
      end
      WAIT_START: begin
        if (!ABAUD)    state_next = IDLE;
        else if (fall) state_next = WAIT_R1;
      end
      WAIT_R1: begin
        if (!ABAUD) begin
          state_next = IDLE;
        end else if (rise) begin
          state_next = MEASURE;
          start_meas = 1'b1;
        end
      end
      MEASURE: begin
        // The 5th rising edge opens the stop bit, eight bit periods after the first
        if (!ABAUD)                           state_next = IDLE;
        else if (rise && edge_cnt_reg == 3'd4) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      edge_cnt_reg <= 3'd0;
    end else if (start_meas) begin
      cnt_reg      <= '0;
      edge_cnt_reg <= 3'd1;
    end else if (state_reg == MEASURE) begin
      if (tick && !cnt_max) cnt_reg <= cnt_reg + 1'b1;
      if (rise)             edge_cnt_reg <= edge_cnt_reg + 3'd1;
    end
  end

  // DONE always publishes, even if ABAUD drops in that same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out    <= 8'h00;
      UxRXIF <= 1'b0;
    end else if (state_reg == DONE) begin
      out    <= cnt_max ? 8'hFF : cnt_reg[CNT_W-1:CNT_W-8];
      UxRXIF <= 1'b1;
    end else if (!ABAUD) begin
      UxRXIF <= 1'b0;
    end
  end

`ifdef ABR_OVF_EN
  logic abaud_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abaud_prev_reg <= 1'b0;
      ABDOVF         <= 1'b0;
    end else begin
      abaud_prev_reg <= ABAUD;
      if (ABAUD && !abaud_prev_reg) begin
        ABDOVF <= 1'b0;
      end else if (state_reg == MEASURE && cnt_max) begin
        ABDOVF <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_abr_ckt.sv
// Directed bench for abr_ckt: vector table on a PRESCALE=1 instance plus hand sequences.
module tb_abr_ckt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abaud1, rx1, rxif1;
  logic [7:0] out1;
  logic       abaud4, rx4, rxif4;
  logic [7:0] out4;
`ifdef ABR_OVF_EN
  logic       ovf1, ovf4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  abr_ckt #(.PRESCALE(1), .CNT_W(11)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ABAUD  (abaud1),
    .UxRX   (rx1),
    .UxRXIF (rxif1),
`ifdef ABR_OVF_EN
    .ABDOVF (ovf1),
`endif
    .out    (out1)
  );

  abr_ckt #(.PRESCALE(4), .CNT_W(11)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ABAUD  (abaud4),
    .UxRX   (rx4),
    .UxRXIF (rxif4),
`ifdef ABR_OVF_EN
    .ABDOVF (ovf4),
`endif
    .out    (out4)
  );

  typedef struct {
    int         per;
    logic       abaud;
    logic [7:0] exp_out;
    logic       exp_if;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive_bit(input int which, input logic b, input int ncyc);
    if (which == 1) rx1 = b;
    else            rx4 = b;
    repeat (ncyc) @(negedge clk);
  endtask

  // Start bit, 0x55 LSB first, stop bit, then a short idle tail
  task automatic send55(input int which, input int per);
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) drive_bit(which, frame[i], per);
    repeat (4) @(negedge clk);
  endtask

  task automatic rearm1;
    abaud1 = 1'b0;
    repeat (2) @(negedge clk);
    abaud1 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [9:0] frame;
    frame  = {1'b1, 8'h55, 1'b0};
    rst_n  = 1'b0;
    abaud1 = 1'b0;
    abaud4 = 1'b0;
    rx1    = 1'b1;
    rx4    = 1'b1;

    vecs[0] = '{per: 16,  abaud: 1'b0, exp_out: 8'd0,   exp_if: 1'b0, exp_ovf: 1'b0};
    vecs[1] = '{per: 16,  abaud: 1'b1, exp_out: 8'd16,  exp_if: 1'b1, exp_ovf: 1'b0};
    vecs[2] = '{per: 20,  abaud: 1'b1, exp_out: 8'd20,  exp_if: 1'b1, exp_ovf: 1'b0};
    vecs[3] = '{per: 9,   abaud: 1'b1, exp_out: 8'd9,   exp_if: 1'b1, exp_ovf: 1'b0};
    vecs[4] = '{per: 300, abaud: 1'b1, exp_out: 8'hFF,  exp_if: 1'b1, exp_ovf: 1'b1};
    vecs[5] = '{per: 33,  abaud: 1'b1, exp_out: 8'd33,  exp_if: 1'b1, exp_ovf: 1'b0};

    repeat (3) @(negedge clk);
    check("reset out1", 32'(out1), 32'd0);
    check("reset rxif1", 32'(rxif1), 32'd0);
    check("reset out4", 32'(out4), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      abaud1 = 1'b0;
      repeat (2) @(negedge clk);
      abaud1 = vecs[v].abaud;
      repeat (2) @(negedge clk);
      send55(1, vecs[v].per);
      check($sformatf("vec%0d out", v), 32'(out1), 32'(vecs[v].exp_out));
      check($sformatf("vec%0d rxif", v), 32'(rxif1), 32'(vecs[v].exp_if));
`ifdef ABR_OVF_EN
      check($sformatf("vec%0d abdovf", v), 32'(ovf1), 32'(vecs[v].exp_ovf));
`endif
    end

    // Flag must hold while ABAUD stays high
    repeat (5) @(negedge clk);
    check("rxif1 holds", 32'(rxif1), 32'd1);

    // Prescaled instance: 160 clk/bit at 4 clk/tick -> 40 ticks
    abaud4 = 1'b1;
    repeat (2) @(negedge clk);
    send55(4, 160);
    check("ps4 out", 32'(out4), 32'd40);
    check("ps4 rxif", 32'(rxif4), 32'd1);
    abaud4 = 1'b0;
    @(negedge clk);
    check("ps4 rxif clear", 32'(rxif4), 32'd0);
    check("ps4 out hold", 32'(out4), 32'd40);

    // Abort after the 3rd rising edge (start of bit 4 in the frame)
    rearm1();
    for (int i = 0; i < 5; i++) drive_bit(1, frame[i], 24);
    drive_bit(1, frame[5], 8);
    abaud1 = 1'b0;
    drive_bit(1, frame[5], 16);
    for (int i = 6; i < 10; i++) drive_bit(1, frame[i], 24);
    repeat (4) @(negedge clk);
    check("abort rxif", 32'(rxif1), 32'd0);
    check("abort out hold", 32'(out1), 32'd33);
    abaud1 = 1'b1;
    repeat (2) @(negedge clk);
    send55(1, 24);
    check("rearm out", 32'(out1), 32'd24);
    check("rearm rxif", 32'(rxif1), 32'd1);

    // Asynchronous reset in the middle of a measurement
    rearm1();
    for (int i = 0; i < 3; i++) drive_bit(1, frame[i], 24);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out", 32'(out1), 32'd0);
    check("async rst rxif", 32'(rxif1), 32'd0);
    rx1 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send55(1, 16);
    check("post rst out", 32'(out1), 32'd16);
    check("post rst rxif", 32'(rxif1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
